// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command framer: sync marker, parser states
// and the command codes understood by the Space Exploration game FSM.
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef logic [2:0] parser_state_t;

  localparam parser_state_t ST_IDLE    = 3'd0;
  localparam parser_state_t ST_CMD     = 3'd1;
  localparam parser_state_t ST_LEN     = 3'd2;
  localparam parser_state_t ST_PAYLOAD = 3'd3;
  localparam parser_state_t ST_CHK     = 3'd4;

  typedef enum logic [7:0] {
    CMD_START = 8'h53,
    CMD_PAUSE = 8'h50,
    CMD_RST   = 8'h52,
    CMD_MOVE  = 8'h4D
  } cmd_code_e;

endpackage

// File: rtl/uart_cmd_gap_timer.sv
// Inter-byte gap watchdog: counts idle cycles inside a frame and flags the
// cycle on which the allowed gap runs out without a new byte arriving.
module uart_cmd_gap_timer #(
  parameter int TIMEOUT_CYC = 86800
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 2);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

  // A byte arriving on the expiry cycle clears the count and wins the race.
  assign expire = enable && !clear && (count == LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames the UART byte stream (SYNC, CMD, LEN, PAYLOAD, CHK) into validated
// game commands held in a one-entry valid/ready output register.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
  parameter int         MAX_LEN     = 4,
  parameter int         TIMEOUT_CYC = 86800
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [7:0]           cmd_code,
  output logic [3:0]           cmd_len,
  output logic [8*MAX_LEN-1:0] cmd_payload,
  output logic                 err_chk,
  output logic                 err_len,
  output logic                 err_timeout,
  output logic                 err_overrun
);

  parser_state_t        state;
  logic [7:0]           code_q;
  logic [7:0]           xor_q;
  logic [3:0]           len_q;
  logic [2:0]           idx_q;
  logic [8*MAX_LEN-1:0] buf_q;
  logic                 expire;
  logic                 in_frame;
  logic                 frame_good;
  logic                 frame_bad;
  logic                 accept;

  assign in_frame = (state != ST_IDLE);

  uart_cmd_gap_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_gap_timer (
    .clk   (clk),
    .reset (reset),
    .clear (rx_valid),
    .enable(in_frame),
    .expire(expire)
  );

  assign frame_good = rx_valid && (state == ST_CHK) && (rx_data == xor_q);
  assign frame_bad  = rx_valid && (state == ST_CHK) && (rx_data != xor_q);
  assign accept     = cmd_valid && cmd_ready;

  // Parser: one rx byte per transition; sync values inside a frame are data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      code_q      <= '0;
      xor_q       <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      buf_q       <= '0;
      err_chk     <= 1'b0;
      err_len     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_len     <= 1'b0;
      err_chk     <= frame_bad;
      err_timeout <= expire;
      if (expire) begin
        state <= ST_IDLE;
      end else if (rx_valid) begin
        case (state)
          ST_IDLE: begin
            if (rx_data == SYNC_BYTE) state <= ST_CMD;
          end
          ST_CMD: begin
            code_q <= rx_data;
            xor_q  <= rx_data;
            state  <= ST_LEN;
          end
          ST_LEN: begin
            len_q <= rx_data[3:0];
            xor_q <= xor_q ^ rx_data;
            buf_q <= '0;
            idx_q <= '0;
            if (rx_data > 8'(MAX_LEN)) begin
              err_len <= 1'b1;
              state   <= ST_IDLE;
            end else if (rx_data == 8'd0) begin
              state <= ST_CHK;
            end else begin
              state <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            xor_q <= xor_q ^ rx_data;
            for (int i = 0; i < MAX_LEN; i++) begin
              if (idx_q == 3'(i)) buf_q[8*i +: 8] <= rx_data;
            end
            idx_q <= idx_q + 3'd1;
            if ({1'b0, idx_q} == (len_q - 4'd1)) state <= ST_CHK;
          end
          ST_CHK: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Output register: a good frame loads when the slot is free or draining now.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_valid   <= 1'b0;
      cmd_code    <= '0;
      cmd_len     <= '0;
      cmd_payload <= '0;
      err_overrun <= 1'b0;
    end else begin
      err_overrun <= 1'b0;
      if (frame_good && (!cmd_valid || accept)) begin
        cmd_valid   <= 1'b1;
        cmd_code    <= code_q;
        cmd_len     <= len_q;
        cmd_payload <= buf_q;
      end else begin
        if (frame_good) err_overrun <= 1'b1;
        if (accept)     cmd_valid   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: directed frames push expected commands
// and error pulses; a negedge monitor pops and compares what the DUT presents.
module tb_uart_cmd_parser;
  import uart_cmd_pkg::*;

  localparam int MAX_LEN     = 4;
  localparam int TIMEOUT_CYC = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [7:0]           cmd_code;
  logic [3:0]           cmd_len;
  logic [8*MAX_LEN-1:0] cmd_payload;
  logic                 err_chk;
  logic                 err_len;
  logic                 err_timeout;
  logic                 err_overrun;

  uart_cmd_parser #(
    .SYNC_BYTE  (8'hA5),
    .MAX_LEN    (MAX_LEN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_code   (cmd_code),
    .cmd_len    (cmd_len),
    .cmd_payload(cmd_payload),
    .err_chk    (err_chk),
    .err_len    (err_len),
    .err_timeout(err_timeout),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  typedef struct {
    logic [7:0]  code;
    logic [3:0]  len;
    logic [31:0] payload;
    int          cyc;
  } exp_cmd_t;

  // kind bits: {overrun, timeout, len, chk}
  typedef struct {
    logic [3:0] kind;
    int         cyc;
  } exp_err_t;

  localparam logic [3:0] K_CHK     = 4'b0001;
  localparam logic [3:0] K_LEN     = 4'b0010;
  localparam logic [3:0] K_TIMEOUT = 4'b0100;
  localparam logic [3:0] K_OVERRUN = 4'b1000;

  exp_cmd_t exp_cmd[$];
  exp_err_t exp_err[$];

  int checks = 0;
  int errors = 0;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] want);
    checks++;
    if (actual !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, want);
    end
  endtask

  // Called at a negedge: byte is sampled on the next posedge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  // Byte k of a sequence started now is sampled on cycle cycle_cnt+1+2k.
  task automatic expect_cmd(input logic [7:0] code, input logic [3:0] len,
                            input logic [31:0] payload, input int nbytes);
    exp_cmd_t e;
    e.code    = code;
    e.len     = len;
    e.payload = payload;
    e.cyc     = cycle_cnt + 2*nbytes - 1;
    exp_cmd.push_back(e);
  endtask

  task automatic expect_err(input logic [3:0] kind, input int cyc);
    exp_err_t e;
    e.kind = kind;
    e.cyc  = cyc;
    exp_err.push_back(e);
  endtask

  // Monitor
  logic prev_valid = 1'b0;
  logic prev_hs    = 1'b0;
  int   load_cyc   = 0;

  always @(negedge clk) begin
    exp_cmd_t ec;
    exp_err_t ee;
    #1;
    if (reset) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (cmd_valid && (!prev_valid || prev_hs)) load_cyc = cycle_cnt;
      if (err_chk || err_len || err_timeout || err_overrun) begin
        if (exp_err.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_err: got kind 0x%0h at cycle %0d, want none",
                   {err_overrun, err_timeout, err_len, err_chk}, cycle_cnt);
        end else begin
          ee = exp_err.pop_front();
          check_output("err_kind", 64'({err_overrun, err_timeout, err_len, err_chk}), 64'(ee.kind));
          check_output("err_cycle", 64'(cycle_cnt), 64'(ee.cyc));
        end
      end
      if (cmd_valid && cmd_ready) begin
        if (exp_cmd.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_cmd: got code 0x%0h, want none", cmd_code);
        end else begin
          ec = exp_cmd.pop_front();
          check_output("cmd_code", 64'(cmd_code), 64'(ec.code));
          check_output("cmd_len", 64'(cmd_len), 64'(ec.len));
          check_output("cmd_payload", 64'(cmd_payload), 64'(ec.payload));
          check_output("cmd_load_cycle", 64'(load_cyc), 64'(ec.cyc));
        end
      end
      prev_valid = cmd_valid;
      prev_hs    = cmd_valid && cmd_ready;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c53;
    logic [7:0] frame[$];
    reset     = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    cmd_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_output("reset_outputs",
                 64'({cmd_valid, cmd_code, cmd_len, cmd_payload,
                      err_chk, err_len, err_timeout, err_overrun}), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] single-byte START frame");
    expect_cmd(CMD_START, 4'd1, 32'h0000_0007, 5);
    frame = '{8'hA5, 8'h53, 8'h01, 8'h07, 8'h55};
    apply_stimulus(frame);

    $display("[TB] leading garbage then PAUSE with empty payload");
    expect_cmd(CMD_PAUSE, 4'd0, 32'h0, 6);
    frame = '{8'h00, 8'hFF, 8'hA5, 8'h50, 8'h00, 8'h50};
    apply_stimulus(frame);

    $display("[TB] bad checksum, then full-length MOVE with sync byte as data");
    expect_err(K_CHK, cycle_cnt + 1 + 2*4);
    frame = '{8'hA5, 8'h53, 8'h01, 8'h07, 8'h54};
    apply_stimulus(frame);
    expect_cmd(CMD_MOVE, 4'd4, 32'h0302_01A5, 8);
    frame = '{8'hA5, 8'h4D, 8'h04, 8'hA5, 8'h01, 8'h02, 8'h03, 8'hEC};
    apply_stimulus(frame);
    expect_cmd(CMD_START, 4'd1, 32'h0000_0007, 5);
    frame = '{8'hA5, 8'h53, 8'h01, 8'h07, 8'h55};
    apply_stimulus(frame);

    $display("[TB] oversize LEN, trailing bytes ignored");
    expect_err(K_LEN, cycle_cnt + 1 + 2*2);
    frame = '{8'hA5, 8'h53, 8'h05, 8'h01, 8'h02};
    apply_stimulus(frame);
    expect_cmd(CMD_MOVE, 4'd2, 32'h0000_2211, 6);
    frame = '{8'hA5, 8'h4D, 8'h02, 8'h11, 8'h22, 8'h7C};
    apply_stimulus(frame);

    $display("[TB] inter-byte timeout");
    send_byte(8'hA5);
    c53 = cycle_cnt + 1;
    expect_err(K_TIMEOUT, c53 + TIMEOUT_CYC - 1);
    send_byte(8'h53);
    repeat (TIMEOUT_CYC + 4) @(negedge clk);

    $display("[TB] byte on the expiry cycle suppresses the timeout");
    send_byte(8'hA5);
    c53 = cycle_cnt + 1;
    send_byte(8'h53);
    while (cycle_cnt < c53 + TIMEOUT_CYC - 2) @(negedge clk);
    expect_cmd(CMD_START, 4'd0, 32'h0, 2);
    send_byte(8'h00);
    send_byte(8'h53);

    $display("[TB] held output, overrun, then load during acceptance");
    cmd_ready = 1'b0;
    expect_cmd(CMD_START, 4'd1, 32'h0000_0007, 5);
    frame = '{8'hA5, 8'h53, 8'h01, 8'h07, 8'h55};
    apply_stimulus(frame);
    expect_err(K_OVERRUN, cycle_cnt + 1 + 2*3);
    frame = '{8'hA5, 8'h50, 8'h00, 8'h50};
    apply_stimulus(frame);
    check_output("held_valid", 64'(cmd_valid), 64'(1));
    check_output("held_code", 64'(cmd_code), 64'(8'h53));
    expect_cmd(CMD_RST, 4'd0, 32'h0, 4);
    send_byte(8'hA5);
    send_byte(8'h52);
    send_byte(8'h00);
    cmd_ready = 1'b1;
    send_byte(8'h52);

    for (int i = 0; i < 40 && (exp_cmd.size() != 0 || exp_err.size() != 0); i++)
      @(negedge clk);
    repeat (4) @(negedge clk);
    check_output("cmd_queue_empty", 64'(exp_cmd.size()), 64'(0));
    check_output("err_queue_empty", 64'(exp_err.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
